depth_test_unit: RTL

Parametrised per-fragment depth-test stage between the rasteriser and the frame/depth buffer BRAMs. It issues a depth read per drawing fragment and waits a configurable memory latency. It then compares the stored depth to the incoming depth under a run-time compare mode, and emits gated framebuffer and depth writes. It adds clear pass-through, optional read-after-write forwarding for back-to-back fragments on the same pixel, and pass/fail statistics.

---
 rtl/depth_test_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/depth_test_unit.sv
// Per-fragment depth test: issues the depth read, aligns it with the fragment, applies the compare mode
// and emits gated framebuffer/depth writes plus pass/fail statistics. Define DEPTH_FORWARD_EN for same-pixel write forwarding.
module depth_test_unit #(
  parameter int FB_BIT_WIDTH    = 16,
  parameter int DEPTH_BIT_WIDTH = 16,
  parameter int FB_ADDR_WIDTH   = 17,
  parameter int READ_LATENCY    = 2,
  parameter int STAT_WIDTH      = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       frag_valid_in,
  input  logic                       frag_clear_in,
  input  logic                       frag_buf_in,
  input  logic [FB_ADDR_WIDTH-1:0]   frag_addr_in,
  input  logic [FB_BIT_WIDTH-1:0]    frag_color_in,
  input  logic [DEPTH_BIT_WIDTH-1:0] frag_depth_in,
  input  logic [2:0]                 cmp_mode_in,
  input  logic                       depth_wr_en_in,
  input  logic                       stats_clr_in,
  output logic                       dp_re_out,
  output logic [FB_ADDR_WIDTH-1:0]   dp_read_addr_out,
  input  logic [DEPTH_BIT_WIDTH-1:0] dp_read_in,
  output logic                       fb_we_out,
  output logic                       dp_we_out,
  output logic                       fb_front_out,
  output logic [FB_ADDR_WIDTH-1:0]   fb_write_out,
  output logic [FB_ADDR_WIDTH-1:0]   dp_write_out,
  output logic [FB_BIT_WIDTH-1:0]    fb_value_out,
  output logic [DEPTH_BIT_WIDTH-1:0] dp_value_out,
  output logic                       busy_out,
  output logic [STAT_WIDTH-1:0]      pass_count_out,
  output logic [STAT_WIDTH-1:0]      fail_count_out
);
  localparam int L = READ_LATENCY;

  typedef struct packed {
    logic                       clr;
    logic                       bsel;
    logic [FB_ADDR_WIDTH-1:0]   addr;
    logic [FB_BIT_WIDTH-1:0]    color;
    logic [DEPTH_BIT_WIDTH-1:0] depth;
    logic [2:0]                 mode;
    logic                       wen;
  } frag_t;

  logic [L-1:0] vld_q, vld_d;
  frag_t        pipe_q [L];
  frag_t        pipe_d [L];

  frag_t                      dec;
  logic                       dec_vld;
  logic                       dec_pass;
  logic [DEPTH_BIT_WIDTH-1:0] stored;

  logic                       fb_we_q, fb_we_d, dp_we_q, dp_we_d, bsel_q, bsel_d;
  logic                       out_vld_q, out_vld_d;
  logic [FB_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [FB_BIT_WIDTH-1:0]    color_q, color_d;
  logic [DEPTH_BIT_WIDTH-1:0] dval_q, dval_d;
  logic [STAT_WIDTH-1:0]      pass_q, pass_d, fail_q, fail_d;

  function automatic logic cmp_pass(input logic [2:0] mode,
                                    input logic [DEPTH_BIT_WIDTH-1:0] n,
                                    input logic [DEPTH_BIT_WIDTH-1:0] s);
    case (mode)
      3'd0:    cmp_pass = 1'b0;
      3'd1:    cmp_pass = (n <  s);
      3'd2:    cmp_pass = (n <= s);
      3'd3:    cmp_pass = (n >  s);
      3'd4:    cmp_pass = (n >= s);
      3'd5:    cmp_pass = (n == s);
      3'd6:    cmp_pass = (n != s);
      default: cmp_pass = 1'b1;
    endcase
  endfunction

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] c);
    sat_inc = (&c) ? c : c + STAT_WIDTH'(1);
  endfunction

  assign dp_re_out        = frag_valid_in & ~frag_clear_in;
  assign dp_read_addr_out = frag_addr_in;

  always_comb begin
    vld_d[0]        = frag_valid_in;
    pipe_d[0].clr   = frag_clear_in;
    pipe_d[0].bsel  = frag_buf_in;
    pipe_d[0].addr  = frag_addr_in;
    pipe_d[0].color = frag_color_in;
    pipe_d[0].depth = frag_depth_in;
    pipe_d[0].mode  = cmp_mode_in;
    pipe_d[0].wen   = depth_wr_en_in;
    for (int i = 1; i < L; i++) begin
      vld_d[i]  = vld_q[i-1];
      pipe_d[i] = pipe_q[i-1];
    end
  end

`ifdef DEPTH_FORWARD_EN
  // History of writes emitted before the one now in the output register; together they cover every
  // write the aligned read could not have observed.
  logic                       hist_we_q   [L];
  logic                       hist_we_d   [L];
  logic [FB_ADDR_WIDTH-1:0]   hist_addr_q [L];
  logic [FB_ADDR_WIDTH-1:0]   hist_addr_d [L];
  logic [DEPTH_BIT_WIDTH-1:0] hist_val_q  [L];
  logic [DEPTH_BIT_WIDTH-1:0] hist_val_d  [L];

  always_comb begin
    hist_we_d[0]   = dp_we_q;
    hist_addr_d[0] = waddr_q;
    hist_val_d[0]  = dval_q;
    for (int i = 1; i < L; i++) begin
      hist_we_d[i]   = hist_we_q[i-1];
      hist_addr_d[i] = hist_addr_q[i-1];
      hist_val_d[i]  = hist_val_q[i-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < L; i++) hist_we_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < L; i++) hist_we_q[i] <= hist_we_d[i];
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < L; i++) begin
      hist_addr_q[i] <= hist_addr_d[i];
      hist_val_q[i]  <= hist_val_d[i];
    end
  end
`endif

  always_comb begin
    dec     = pipe_q[L-1];
    dec_vld = vld_q[L-1];
    stored  = dp_read_in;
`ifdef DEPTH_FORWARD_EN
    // Oldest first so the youngest matching write wins.
    for (int i = L - 1; i >= 0; i--) begin
      if (hist_we_q[i] && (hist_addr_q[i] == dec.addr)) stored = hist_val_q[i];
    end
    if (dp_we_q && (waddr_q == dec.addr)) stored = dval_q;
`endif
    dec_pass = cmp_pass(dec.mode, dec.depth, stored);
  end

  always_comb begin
    fb_we_d   = 1'b0;
    dp_we_d   = 1'b0;
    bsel_d    = bsel_q;
    waddr_d   = waddr_q;
    color_d   = color_q;
    dval_d    = dval_q;
    out_vld_d = dec_vld;
    pass_d    = pass_q;
    fail_d    = fail_q;
    if (dec_vld) begin
      if (dec.clr || dec_pass) begin
        fb_we_d = 1'b1;
        dp_we_d = dec.clr | dec.wen;
        bsel_d  = dec.bsel;
        waddr_d = dec.addr;
        color_d = dec.color;
        dval_d  = dec.depth;
      end
      if (!dec.clr) begin
        if (dec_pass) pass_d = sat_inc(pass_q);
        else          fail_d = sat_inc(fail_q);
      end
    end
    if (stats_clr_in) begin
      pass_d = '0;
      fail_d = '0;
    end
  end

  // Stage boundary: pipeline valids, output register and counters.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q     <= '0;
      fb_we_q   <= 1'b0;
      dp_we_q   <= 1'b0;
      bsel_q    <= 1'b0;
      waddr_q   <= '0;
      color_q   <= '0;
      dval_q    <= '0;
      out_vld_q <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
    end else begin
      vld_q     <= vld_d;
      fb_we_q   <= fb_we_d;
      dp_we_q   <= dp_we_d;
      bsel_q    <= bsel_d;
      waddr_q   <= waddr_d;
      color_q   <= color_d;
      dval_q    <= dval_d;
      out_vld_q <= out_vld_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < L; i++) pipe_q[i] <= pipe_d[i];
  end

  assign fb_we_out      = fb_we_q;
  assign dp_we_out      = dp_we_q;
  assign fb_front_out   = bsel_q;
  assign fb_write_out   = waddr_q;
  assign dp_write_out   = waddr_q;
  assign fb_value_out   = color_q;
  assign dp_value_out   = dval_q;
  assign busy_out       = (|vld_q) | out_vld_q;
  assign pass_count_out = pass_q;
  assign fail_count_out = fail_q;
endmodule
